// File: rtl/cpu_pkg.sv
// Shared types for the RV32I pipeline: IF/ID and ID/EX payloads, control word,
// opcode and ALUOp encodings.
package cpu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned REG_AW   = 5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_R      = 2'b10;
   localparam logic [1:0] ALU_OP_I      = 2'b11;

   typedef struct packed {
      logic [XLEN-1:0] pc_address;
      logic [XLEN-1:0] instruc;
   } if_id_data_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   typedef struct packed {
      ctrl_t             ctrl;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [2:0]        funct3;
      logic              funct7_b5;
   } id_ex_data_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports, one write port.
// x0 reads zero and ignores writes; a same-cycle write is bypassed to reads.
// Ports: clock, reset (sync, active-high), rs1_addr/rs2_addr -> rs1_data/rs2_data,
//        we/wr_addr/wr_data write port.
module register_file
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   input  logic              we,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [XLEN-1:0]   wr_data
);

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] regs_d [NUM_REGS];
   logic            wr_en_c;

   assign wr_en_c = we && (wr_addr != '0);

   // Next-state of the array.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_c) regs_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads with x0 forcing and write-through bypass.
   always_comb begin
      rs1_data = regs_q[rs1_addr];
      rs2_data = regs_q[rs2_addr];
      if (wr_en_c && (wr_addr == rs1_addr)) rs1_data = wr_data;
      if (wr_en_c && (wr_addr == rs2_addr)) rs2_data = wr_data;
      if (rs1_addr == '0) rs1_data = '0;
      if (rs2_addr == '0) rs2_data = '0;
   end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control decode, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
// Ports: clock, reset (sync, active-high), ifid_data_in (pc + instruction),
//        wb_reg_write/wb_rd/wb_data write-back, flush (branch squash),
//        idex_data_out (registered ID/EX), PCWrite / if_id_write (0 = stall fetch).
module id_stage
   import cpu_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  if_id_data_t       ifid_data_in,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output id_ex_data_t       idex_data_out,
   output logic              PCWrite,
   output logic              if_id_write
);

   logic [XLEN-1:0]   instr;
   logic [6:0]        opcode;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   ctrl_t             ctrl;
   logic [XLEN-1:0]   imm;
   logic              stall_c;
   id_ex_data_t       idex_d;
   id_ex_data_t       idex_q;

   assign instr  = ifid_data_in.instruc;
   assign opcode = instr[6:0];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   register_file u_regfile (
      .clock    (clock),
      .reset    (reset),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .we       (wb_reg_write),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   // Main control and sign-extended immediate.
   always_comb begin
      ctrl = '0;
      imm  = '0;
      case (opcode)
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OP_R;
         end
         OP_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_OP_I;
            imm            = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.alu_op     = ALU_OP_ADD;
            imm             = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
            imm            = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_OP_BRANCH;
            imm         = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         default: ;
      endcase
   end

   // Load-use hazard against the instruction now in ID/EX; a flush wins.
   assign stall_c = idex_q.ctrl.mem_read && (idex_q.rd != '0) &&
                    ((idex_q.rd == rs1) || (idex_q.rd == rs2)) && !flush;

   assign PCWrite     = !stall_c;
   assign if_id_write = !stall_c;

   // ID/EX next value: flush squashes, stall inserts a bubble (ctrl only).
   always_comb begin
      idex_d           = '0;
      idex_d.ctrl      = ctrl;
      idex_d.pc        = ifid_data_in.pc_address;
      idex_d.rs1_data  = rs1_data;
      idex_d.rs2_data  = rs2_data;
      idex_d.imm       = imm;
      idex_d.rs1       = rs1;
      idex_d.rs2       = rs2;
      idex_d.rd        = instr[11:7];
      idex_d.funct3    = instr[14:12];
      idex_d.funct7_b5 = instr[30];
      if (flush)        idex_d      = '0;
      else if (stall_c) idex_d.ctrl = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) idex_q <= '0;
      else       idex_q <= idex_d;
   end

   assign idex_data_out = idex_q;

endmodule
